// File: rtl/neopixel_strand_controller.sv
// Five-pixel WS2812 strand driver: byte-wise colour store plus a pulse-width
// serialiser that sends the frame MSB first and then holds the line low to latch.
module neopixel_strand_controller #(
  parameter int unsigned NUM_PIX = 5,
  parameter int unsigned T0H     = 18,
  parameter int unsigned T0L     = 40,
  parameter int unsigned T1H     = 35,
  parameter int unsigned T1L     = 30,
  parameter int unsigned TLATCH  = 2500
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               color_level,
  input  logic [1:0]               color_index,
  input  logic [2:0]               pixel_index,
  input  logic                     load_color,
  input  logic                     send_it,
  output logic                     neo_data,
  output logic                     ready_to_load,
  output logic                     ready_to_send,
  output logic [24*NUM_PIX-1:0]    display_packet
);

  localparam int unsigned FRAME_BITS = 24 * NUM_PIX;
  localparam int unsigned IDX_W      = $clog2(FRAME_BITS);
  localparam int unsigned BIT_W      = $clog2(FRAME_BITS + 1);
  localparam int unsigned CNT_W      = $clog2(TLATCH + T0H + T0L + T1H + T1L + 1);

  localparam logic [CNT_W-1:0] T0H_END    = CNT_W'(T0H - 1);
  localparam logic [CNT_W-1:0] T0L_END    = CNT_W'(T0L - 1);
  localparam logic [CNT_W-1:0] T1H_END    = CNT_W'(T1H - 1);
  localparam logic [CNT_W-1:0] T1L_END    = CNT_W'(T1L - 1);
  localparam logic [CNT_W-1:0] TLATCH_END = CNT_W'(TLATCH - 1);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND_HIGH,
    SEND_LOW,
    WAIT_LATCH
  } state_t;

  state_t                 state;
  logic [FRAME_BITS-1:0]  shift_reg;
  logic [BIT_W-1:0]       bit_cnt;
  logic [CNT_W-1:0]       cyc_cnt;

  logic                   wr_valid;
  logic                   wr_accept;
  int unsigned            lsb_full;
  logic [IDX_W-1:0]       wr_lsb;
  logic                   cur_bit;

  // Pixel 0 occupies the top 24 bits; within a pixel the byte order is G,R,B.
  always_comb begin
    wr_valid = 1'b0;
    lsb_full = 0;
    if (color_index != 2'b11 && 32'(pixel_index) < NUM_PIX) begin
      wr_valid = 1'b1;
      lsb_full = (NUM_PIX - 1 - 32'(pixel_index)) * 24;
      if (color_index == 2'b00)
        lsb_full = lsb_full + 8;
      else if (color_index == 2'b10)
        lsb_full = lsb_full + 16;
    end
  end

  assign wr_lsb    = IDX_W'(lsb_full);
  assign cur_bit   = shift_reg[FRAME_BITS-1];
  // A simultaneous send in IDLE takes priority and drops the load.
  assign wr_accept = load_color && wr_valid &&
                     (state == WAIT_LATCH || (state == IDLE && !send_it));

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      display_packet <= '0;
      shift_reg      <= '0;
      bit_cnt        <= '0;
      cyc_cnt        <= '0;
      neo_data       <= 1'b0;
      ready_to_load  <= 1'b1;
      ready_to_send  <= 1'b1;
    end else begin
      if (wr_accept)
        display_packet[wr_lsb +: 8] <= color_level;

      case (state)
        IDLE: begin
          if (send_it) begin
            state         <= SEND_HIGH;
            shift_reg     <= display_packet;
            bit_cnt       <= '0;
            cyc_cnt       <= '0;
            neo_data      <= 1'b1;
            ready_to_load <= 1'b0;
            ready_to_send <= 1'b0;
          end
        end

        SEND_HIGH: begin
          if (cyc_cnt == (cur_bit ? T1H_END : T0H_END)) begin
            state    <= SEND_LOW;
            cyc_cnt  <= '0;
            neo_data <= 1'b0;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        SEND_LOW: begin
          if (cyc_cnt == (cur_bit ? T1L_END : T0L_END)) begin
            cyc_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              state         <= WAIT_LATCH;
              ready_to_load <= 1'b1;
            end else begin
              state     <= SEND_HIGH;
              bit_cnt   <= bit_cnt + 1'b1;
              shift_reg <= shift_reg << 1;
              neo_data  <= 1'b1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        WAIT_LATCH: begin
          if (cyc_cnt == TLATCH_END) begin
            state         <= IDLE;
            cyc_cnt       <= '0;
            ready_to_send <= 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neopixel_strand_controller.sv
// Self-checking bench for neopixel_strand_controller: pixel-array colour model
// plus per-bit pulse-width expectations derived from the modelled frame.
module tb_neopixel_strand_controller;

  localparam int NUM_PIX = 5;
  localparam int T0H = 18, T0L = 40, T1H = 35, T1L = 30, TLATCH = 2500;
  localparam int FRAME = 24 * NUM_PIX;

  logic             clock = 1'b0;
  logic             reset;
  logic [7:0]       color_level;
  logic [1:0]       color_index;
  logic [2:0]       pixel_index;
  logic             load_color;
  logic             send_it;
  logic             neo_data;
  logic             ready_to_load;
  logic             ready_to_send;
  logic [FRAME-1:0] display_packet;

  int checks = 0;
  int errors = 0;

  // pix[p][0]=G, [1]=R, [2]=B
  logic [7:0] pix [NUM_PIX][3];

  neopixel_strand_controller #(
    .NUM_PIX(NUM_PIX), .T0H(T0H), .T0L(T0L), .T1H(T1H), .T1L(T1L), .TLATCH(TLATCH)
  ) dut (
    .clock(clock), .reset(reset),
    .color_level(color_level), .color_index(color_index), .pixel_index(pixel_index),
    .load_color(load_color), .send_it(send_it),
    .neo_data(neo_data), .ready_to_load(ready_to_load), .ready_to_send(ready_to_send),
    .display_packet(display_packet)
  );

  always #10 clock = ~clock;

  function automatic logic [FRAME-1:0] model_packet();
    logic [FRAME-1:0] pkt = '0;
    for (int p = 0; p < NUM_PIX; p++)
      pkt = (pkt << 24) | {{(FRAME-24){1'b0}}, pix[p][0], pix[p][1], pix[p][2]};
    return pkt;
  endfunction

  task automatic model_clear();
    for (int p = 0; p < NUM_PIX; p++)
      for (int c = 0; c < 3; c++)
        pix[p][c] = 8'h00;
  endtask

  task automatic model_load(input int p, input int ci, input logic [7:0] lvl);
    if (ci != 3 && p < NUM_PIX) begin
      case (ci)
        0: pix[p][1] = lvl;
        1: pix[p][2] = lvl;
        default: pix[p][0] = lvl;
      endcase
    end
  endtask

  // Called at a negedge; leaves the bench at the following negedge.
  task automatic drive_load(input int p, input int ci, input logic [7:0] lvl);
    pixel_index = 3'(p);
    color_index = 2'(ci);
    color_level = lvl;
    load_color  = 1'b1;
    @(negedge clock);
    load_color  = 1'b0;
    model_load(p, ci, lvl);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_clear();
    checks += 4;
    if (neo_data !== 1'b0) begin errors++; $display("FAIL reset_neo: got %b want 0", neo_data); end
    if (ready_to_load !== 1'b1) begin errors++; $display("FAIL reset_rtl: got %b want 1", ready_to_load); end
    if (ready_to_send !== 1'b1) begin errors++; $display("FAIL reset_rts: got %b want 1", ready_to_send); end
    if (display_packet !== '0) begin errors++; $display("FAIL reset_packet: got %h want 0", display_packet); end
  endtask

  task automatic test_spec_loads();
    logic [FRAME-1:0] want = 120'h005073_000000_B30000_000000_00FF00;
    drive_load(4, 0, 8'hFF);
    drive_load(0, 1, 8'h73);
    drive_load(2, 2, 8'hB3);
    drive_load(1, 3, 8'hD4);
    drive_load(0, 0, 8'h50);
    checks += 2;
    if (display_packet !== want) begin
      errors++; $display("FAIL spec_loads: got %h want %h", display_packet, want);
    end
    if (display_packet[95:72] !== 24'h0) begin
      errors++; $display("FAIL pixel1_zero: got %h want 000000", display_packet[95:72]);
    end
  endtask

  task automatic test_random_loads(input int n);
    for (int i = 0; i < n; i++) begin
      drive_load(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 8'($urandom));
      checks++;
      if (display_packet !== model_packet()) begin
        errors++; $display("FAIL rand_load[%0d]: got %h want %h", i, display_packet, model_packet());
      end
    end
  endtask

  // Sends one frame and checks every pulse width. inject: try load/send while busy
  // and load during latch. send_load: assert a load together with send_it.
  task automatic test_frame(input bit inject, input bit send_load);
    logic [FRAME-1:0] exp = model_packet();
    int hi, lo, want_hi, want_lo;
    bit busy_bad = 0, latch_neo_bad = 0, latch_rdy_bad = 0;

    send_it = 1'b1;
    if (send_load) begin
      pixel_index = 3'd2; color_index = 2'd1; color_level = 8'h5A; load_color = 1'b1;
    end
    @(negedge clock);
    send_it = 1'b0;
    load_color = 1'b0;
    checks++;
    if (neo_data !== 1'b1) begin errors++; $display("FAIL send_latency: neo %b want 1", neo_data); end

    for (int b = 0; b < FRAME; b++) begin
      want_hi = exp[FRAME-1-b] ? T1H : T0H;
      want_lo = exp[FRAME-1-b] ? T1L : T0L;
      hi = 0;
      while (neo_data === 1'b1 && hi < 1000) begin
        if (ready_to_load !== 1'b0 || ready_to_send !== 1'b0) busy_bad = 1;
        if (inject && b == 3 && hi == 2) begin
          pixel_index = 3'd3; color_index = 2'd0; color_level = 8'hAA;
          load_color = 1'b1; send_it = 1'b1;
        end
        @(negedge clock);
        load_color = 1'b0; send_it = 1'b0;
        hi++;
      end
      checks++;
      if (hi != want_hi) begin errors++; $display("FAIL bit%0d_high: got %0d want %0d", b, hi, want_hi); end
      if (inject && b == 3) begin
        checks++;
        if (display_packet !== exp) begin
          errors++; $display("FAIL busy_load: got %h want %h", display_packet, exp);
        end
      end
      lo = 0;
      if (b < FRAME - 1) begin
        while (neo_data === 1'b0 && lo < 1000) begin
          if (ready_to_load !== 1'b0 || ready_to_send !== 1'b0) busy_bad = 1;
          @(negedge clock);
          lo++;
        end
        checks++;
        if (lo != want_lo) begin errors++; $display("FAIL bit%0d_low: got %0d want %0d", b, lo, want_lo); end
      end else begin
        while (ready_to_send !== 1'b1 && lo < 5000) begin
          if (neo_data !== 1'b0) latch_neo_bad = 1;
          if (ready_to_load !== (lo >= want_lo)) latch_rdy_bad = 1;
          if (inject && lo == want_lo + 5) begin
            pixel_index = 3'd3; color_index = 2'd2; color_level = 8'h11;
            load_color = 1'b1; send_it = 1'b1;
          end
          @(negedge clock);
          if (inject && lo == want_lo + 5) model_load(3, 2, 8'h11);
          load_color = 1'b0; send_it = 1'b0;
          lo++;
        end
        checks += 3;
        if (lo != want_lo + TLATCH) begin
          errors++; $display("FAIL latch_len: got %0d want %0d", lo, want_lo + TLATCH);
        end
        if (latch_neo_bad) begin errors++; $display("FAIL latch_neo: got high want low"); end
        if (latch_rdy_bad) begin errors++; $display("FAIL latch_ready_to_load: wrong phase"); end
      end
    end

    checks++;
    if (busy_bad) begin errors++; $display("FAIL busy_ready: got 1 want 0 while sending"); end

    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (neo_data !== 1'b0) hi++;
      @(negedge clock);
    end
    checks += 3;
    if (hi != 0) begin errors++; $display("FAIL no_restart: got %0d high cycles want 0", hi); end
    if (ready_to_load !== 1'b1 || ready_to_send !== 1'b1) begin
      errors++; $display("FAIL idle_ready: got %b%b want 11", ready_to_load, ready_to_send);
    end
    if (display_packet !== model_packet()) begin
      errors++; $display("FAIL post_frame_packet: got %h want %h", display_packet, model_packet());
    end
  endtask

  task automatic test_reset_mid_frame();
    int hi = 0;
    send_it = 1'b1;
    @(negedge clock);
    send_it = 1'b0;
    repeat (300) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_clear();
    checks += 4;
    if (neo_data !== 1'b0) begin errors++; $display("FAIL midrst_neo: got %b want 0", neo_data); end
    if (ready_to_load !== 1'b1) begin errors++; $display("FAIL midrst_rtl: got %b want 1", ready_to_load); end
    if (ready_to_send !== 1'b1) begin errors++; $display("FAIL midrst_rts: got %b want 1", ready_to_send); end
    if (display_packet !== '0) begin errors++; $display("FAIL midrst_packet: got %h want 0", display_packet); end
    for (int i = 0; i < 100; i++) begin
      if (neo_data !== 1'b0) hi++;
      @(negedge clock);
    end
    checks++;
    if (hi != 0) begin errors++; $display("FAIL midrst_quiet: got %0d high cycles want 0", hi); end
  endtask

  initial begin
    reset = 1'b1; load_color = 1'b0; send_it = 1'b0;
    color_level = '0; color_index = '0; pixel_index = '0;
    @(negedge clock);
    test_reset();
    test_spec_loads();
    test_frame(1'b1, 1'b0);
    test_random_loads(40);
    test_frame(1'b0, 1'b1);
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
